// File: rtl/counter_tick_ctrl.sv
// counter_tick_ctrl: switch sync/debounce, run/pause/clear FSM and count-enable tick generator
module counter_tick_ctrl #(
  parameter int DIV         = 12000000,
  parameter int DB_CYCLES   = 1000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] sw,
  output logic [1:0] sw_db,
  output logic       run,
  output logic       clr,
  output logic       clr_pulse,
  output logic       tick
);
  localparam int DBW = DB_CYCLES > 1 ? $clog2(DB_CYCLES) : 1;
  localparam int PW  = $clog2(DIV);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, CLEAR} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] sync [2];
  logic [DBW-1:0] db_cnt [2];
  logic [1:0] s;
  logic [PW-1:0] pre;
  assign s = {sync[1][SYNC_STAGES-1], sync[0][SYNC_STAGES-1]};
  always_ff @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (rst) begin
        sync[b]   <= '0;
        db_cnt[b] <= '0;
        sw_db[b]  <= 1'b0;
      end else begin
        sync[b] <= {sync[b][SYNC_STAGES-2:0], sw[b]};
        if (s[b] == sw_db[b]) db_cnt[b] <= '0;
        else if (db_cnt[b] == DBW'(DB_CYCLES - 1)) begin
          sw_db[b]  <= s[b];
          db_cnt[b] <= '0;
        end else db_cnt[b] <= db_cnt[b] + 1'b1;
      end
    end
  end
  // clear dominates every other transition, including sw_db = 11
  always_comb begin
    state_n = sw_db[1] ? CLEAR :
              state == CLEAR ? IDLE :
              (state == IDLE || state == PAUSE) && sw_db == 2'b01 ? RUN :
              state == RUN && sw_db == 2'b00 ? PAUSE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pre       <= '0;
      tick      <= 1'b0;
      clr_pulse <= 1'b0;
    end else begin
      state     <= state_n;
      pre       <= state == RUN ? (pre == PW'(DIV - 1) ? PW'(0) : pre + 1'b1) :
                   state == PAUSE ? pre : PW'(0);
      tick      <= state == RUN && pre == PW'(DIV - 1);
      clr_pulse <= state_n == CLEAR && state != CLEAR;
    end
  end
  assign run = state == RUN;
  assign clr = state == CLEAR;
endmodule

// File: tb/tb_counter_tick_ctrl.sv
// tb_counter_tick_ctrl: scoreboard of hand-timed output changes for counter_tick_ctrl
module tb_counter_tick_ctrl;
  typedef struct {int t; logic [5:0] v;} ev_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] sw = 2'b11;
  logic [1:0] sw_db;
  logic run, clr, clr_pulse, tick;
  logic [5:0] outs, prev;
  int e = 0, tests = 0, fails = 0, b;
  bit mon_en = 1'b0;
  ev_t q[$];
  ev_t x;
  counter_tick_ctrl #(.DIV(10), .DB_CYCLES(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sw(sw), .sw_db(sw_db), .run(run), .clr(clr),
    .clr_pulse(clr_pulse), .tick(tick)
  );
  assign outs = {sw_db, run, clr, clr_pulse, tick};
  always #5 clk = ~clk;
  always @(posedge clk) e <= e + 1;
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic expect_at(input int t, input logic [5:0] v);
    q.push_back('{t, v});
  endtask
  task automatic check_now(input string name, input logic [5:0] v);
    tests++;
    if (outs !== v) begin
      fails++;
      $display("FAIL %s: got %b want %b", name, outs, v);
    end
  endtask
  // every change of {sw_db,run,clr,clr_pulse,tick} must match the next expected event
  always @(negedge clk) begin
    if (mon_en && outs !== prev) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_change: edge %0d got %b, none expected", e, outs);
      end else begin
        x = q.pop_front();
        if (x.t != e || x.v !== outs) begin
          fails++;
          $display("FAIL event: got edge %0d %b want edge %0d %b", e, outs, x.t, x.v);
        end
      end
      prev = outs;
    end
  end
  initial begin
    step(2);
    check_now("reset_state", 6'b000000);
    rst = 1'b0;
    sw = 2'b00;
    prev = outs;
    mon_en = 1'b1;
    step(20);
    check_now("idle_after_release", 6'b000000);
    sw = 2'b01;
    step(3);
    sw = 2'b00;
    step(12);
    check_now("glitch_rejected", 6'b000000);
    b = e;
    sw = 2'b01;
    expect_at(b + 6, 6'b010000);
    expect_at(b + 7, 6'b011000);
    for (int j = 0; j < 3; j++) begin
      expect_at(b + 17 + 10 * j, 6'b011001);
      expect_at(b + 18 + 10 * j, 6'b011000);
    end
    step(36);
    sw = 2'b00;
    expect_at(b + 42, 6'b001000);
    expect_at(b + 43, 6'b000000);
    step(27);
    b = e;
    sw = 2'b01;
    expect_at(b + 6, 6'b010000);
    expect_at(b + 7, 6'b011000);
    expect_at(b + 11, 6'b011001);
    expect_at(b + 12, 6'b011000);
    expect_at(b + 21, 6'b011001);
    expect_at(b + 22, 6'b011000);
    step(20);
    sw = 2'b11;
    expect_at(b + 26, 6'b111000);
    expect_at(b + 27, 6'b110110);
    expect_at(b + 28, 6'b110100);
    step(15);
    b = e;
    sw = 2'b01;
    expect_at(b + 6, 6'b010100);
    expect_at(b + 7, 6'b010000);
    expect_at(b + 8, 6'b011000);
    expect_at(b + 18, 6'b011001);
    expect_at(b + 19, 6'b011000);
    step(27);
    rst = 1'b1;
    sw = 2'b00;
    expect_at(b + 28, 6'b000000);
    step(1);
    check_now("reset_mid_run", 6'b000000);
    step(1);
    rst = 1'b0;
    step(20);
    check_now("idle_after_reset", 6'b000000);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL missing_events: got %0d pending want 0, next edge %0d %b", q.size(), q[0].t, q[0].v);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
